// File: rtl/div_func.sv
// -----------------------------------------------------------------------------
// div_func - unsigned XLEN-bit restoring divider with a configurable pipeline.
//
// One quotient bit is resolved per step, most significant bit first. Setting
// bit i of STAGE_LIST puts a register after step i. Latency is
// LAT = popcount(STAGE_LIST). LAT=0 gives a purely combinational unit, and
// STAGE_LIST of all ones gives one register per step. A new op is accepted
// every cycle, with no backpressure.
//
// Optional feature (macro DIV_FUNC_OUTREG_EN): registers {ack,quo,rem} after
// the final step, so latency becomes LAT+1.
//
// Divide by zero gives quo = all ones and rem = a. This falls out of the
// restoring recurrence itself, so no special case is needed.
//
// Ports
//   clk  in   1     rising-edge clock
//   rst  in   1     asynchronous reset, active low
//   a    in   XLEN  dividend (unsigned)
//   b    in   XLEN  divisor (unsigned)
//   vld  in   1     op request; a/b are sampled in the same cycle
//   quo  out  XLEN  quotient a/b
//   rem  out  XLEN  remainder a%b
//   ack  out  1     quo/rem valid for the op issued LAT cycles earlier
// -----------------------------------------------------------------------------
module div_func #(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  STAGE_LIST = 32'h0101_0101
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            vld,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem,
  output logic            ack
);

  // Stage k holds the inputs of step k. Stage XLEN holds the final result.
  // The partial remainder is always < b after a step, so XLEN bits are
  // enough to store it. Only the shifted value needs the extra bit.
  logic            st_v [0:XLEN];
  logic [XLEN-1:0] st_r [0:XLEN];
  logic [XLEN-1:0] st_q [0:XLEN];
  logic [XLEN-1:0] st_a [0:XLEN];
  logic [XLEN-1:0] st_b [0:XLEN];

  assign st_v[0] = vld;
  assign st_r[0] = '0;
  assign st_q[0] = '0;
  assign st_a[0] = a;
  assign st_b[0] = b;

  for (genvar i = 0; i < XLEN; i++) begin : g_step
    logic [XLEN:0]   sh;
    logic            ge;
    logic [XLEN-1:0] nr;
    logic [XLEN-1:0] nq;

    // Gating with the stage valid keeps bubbles at r=0,q=0. Otherwise an idle
    // stage that sees a zero divisor would produce quotient ones on its own.
    // NOTE: every always_comb output gets a value on every path (nq is
    // copied before its bit is patched), so no latch is inferred.
    always_comb begin
      sh = {st_r[i], st_v[i] & st_a[i][XLEN-1-i]};
      ge = st_v[i] && (sh >= {1'b0, st_b[i]});
      // When ge holds, the true difference is < b, so XLEN-bit modular
      // subtraction is exact.
      nr = ge ? (sh[XLEN-1:0] - st_b[i]) : sh[XLEN-1:0];
      nq = st_q[i];
      nq[XLEN-1-i] = ge;
    end

    if (STAGE_LIST[i]) begin : g_reg
      logic            v_q;
      logic [XLEN-1:0] r_q, q_q, a_q, b_q;

      // NOTE: sequential state uses non-blocking assignments only. The data
      // registers are reset along with valid, so outputs read zero after reset.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v_q <= 1'b0;
          r_q <= '0;
          q_q <= '0;
          a_q <= '0;
          b_q <= '0;
        end else begin
          v_q <= st_v[i];
          r_q <= nr;
          q_q <= nq;
          a_q <= st_a[i];
          b_q <= st_b[i];
        end
      end

      assign st_v[i+1] = v_q;
      assign st_r[i+1] = r_q;
      assign st_q[i+1] = q_q;
      assign st_a[i+1] = a_q;
      assign st_b[i+1] = b_q;
    end else begin : g_comb
      assign st_v[i+1] = st_v[i];
      assign st_r[i+1] = nr;
      assign st_q[i+1] = nq;
      assign st_a[i+1] = st_a[i];
      assign st_b[i+1] = st_b[i];
    end
  end

  // The operands carried past the last step are not needed.
  logic unused_tail;
  assign unused_tail = ^{st_a[XLEN], st_b[XLEN]};

`ifdef DIV_FUNC_OUTREG_EN
  logic            ack_q;
  logic [XLEN-1:0] quo_q, rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q <= 1'b0;
      quo_q <= '0;
      rem_q <= '0;
    end else begin
      ack_q <= st_v[XLEN];
      quo_q <= st_q[XLEN];
      rem_q <= st_r[XLEN];
    end
  end

  assign ack = ack_q;
  assign quo = quo_q;
  assign rem = rem_q;
`else
  // Any steps after the last register are combinational from live inputs
  // (all of them when LAT=0). Masking with rst holds the outputs at zero
  // for the whole reset.
  assign ack = rst & st_v[XLEN];
  assign quo = rst ? st_q[XLEN] : '0;
  assign rem = rst ? st_r[XLEN] : '0;
`endif

endmodule

// File: tb/tb_div_func.sv
// -----------------------------------------------------------------------------
// tb_div_func - self-checking bench for div_func (XLEN=32).
// Uses a table of directed vectors, a back-to-back burst, a reset-in-flight
// sequence and a random sweep. Expected results are queued when an op is
// issued. They are popped and compared on the cycle the op is due.
// -----------------------------------------------------------------------------
module tb_div_func #(
  parameter logic [31:0] STAGE_LIST = 32'h0101_0101
);
  localparam int XLEN = 32;
`ifdef DIV_FUNC_OUTREG_EN
  localparam int OUTREG = 1;
`else
  localparam int OUTREG = 0;
`endif

  function automatic int popcnt(input logic [31:0] m);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(m[i]);
    return n;
  endfunction

  localparam int LAT = popcnt(STAGE_LIST) + OUTREG;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            vld = 1'b0;
  logic [XLEN-1:0] a   = '0;
  logic [XLEN-1:0] b   = '0;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic            ack;

  always #5 clk = ~clk;

  div_func #(.XLEN(XLEN), .STAGE_LIST(STAGE_LIST)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .vld (vld),
    .quo (quo),
    .rem (rem),
    .ack (ack)
  );

  typedef struct {
    int          due;
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, required %h", name, cyc, act, req);
    end
  endtask

  // Outputs are sampled just before each rising edge, when they are stable.
  always @(posedge clk) begin
    exp_t e;
    if (!rst) begin
      check("reset_ack", 32'(ack), 32'd0);
      check("reset_quo", quo, 32'd0);
      check("reset_rem", rem, 32'd0);
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("ack", 32'(ack), 32'd1);
      check("quo", quo, e.q);
      check("rem", rem, e.r);
    end else begin
      check("idle_ack", 32'(ack), 32'd0);
    end
    cyc <= cyc + 1;
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eq, input logic [31:0] er);
    exp_t e;
    @(negedge clk);
    a   = x;
    b   = y;
    vld = 1'b1;
    e.due = cyc + LAT;
    e.q   = eq;
    e.r   = er;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vld = 1'b0;
      a   = '0;
      b   = '0;
    end
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < LAT + 20 && sb.size() > 0; i++) @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    if (y == 0) return {32'hFFFF_FFFF, x};
    return {x / y, x % y};
  endfunction

  vec_t vecs[10];
  vec_t burst[4];

  initial begin
    logic [31:0] x, y;
    logic [63:0] r;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234};
    vecs[2] = '{32'd5,          32'd9,          32'd0,          32'd5};
    vecs[3] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[4] = '{32'd0,          32'd5,          32'd0,          32'd0};
    vecs[5] = '{32'd1000,       32'd10,         32'd100,        32'd0};
    vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
    vecs[7] = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFE};
    vecs[8] = '{32'h8000_0000,  32'd2,          32'h4000_0000,  32'd0};
    vecs[9] = '{32'd7,          32'd0,          32'hFFFF_FFFF,  32'd7};

    burst[0] = '{32'd50, 32'd3, 32'd16, 32'd2};
    burst[1] = '{32'd50, 32'd7, 32'd7,  32'd1};
    burst[2] = '{32'd9,  32'd9, 32'd1,  32'd0};
    burst[3] = '{32'd0,  32'd5, 32'd0,  32'd0};

    // Reset held for a few cycles; the monitor checks zero outputs meanwhile.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Isolated directed ops, each followed by a bubble.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
      idle(LAT + 1);
    end
    drain();

    // Four back-to-back ops must return on four consecutive cycles, in order.
    foreach (burst[i]) issue(burst[i].a, burst[i].b, burst[i].q, burst[i].r);
    drain();

    // Reset two cycles after issue: the in-flight op must never be acked.
    issue(32'd100, 32'd7, 32'd14, 32'd2);
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    idle(2);
    rst = 1'b1;
    idle(1);
    issue(32'd1000, 32'd10, 32'd100, 32'd0);
    drain();

    // Random sweep with irregular bubbles, small and full-range divisors.
    for (int i = 0; i < 200; i++) begin
      x = $urandom;
      y = (i % 2 == 0) ? 32'($urandom) : 32'($urandom & 32'hFF);
      if (i % 37 == 5) y = '0;
      r = ref_div(x, y);
      issue(x, y, r[63:32], r[31:0]);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
